fetch_stage: RTL and testbench

//   Instruction fetch stage feeding the decode/control unit. Holds the PC, issues one

---
 rtl/olivia_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage_perf_counters.sv | 24 ++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/olivia_pkg.sv
// Shared fetch-stage types and constants: address/instruction widths, PC step and FSM encoding.
package olivia_pkg;

   localparam int ADDR_W  = 64;
   localparam int INSTR_W = 32;

   localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

   typedef enum logic [1:0] {
      FETCH = 2'b00,
      WAIT  = 2'b01,
      DROP  = 2'b10,
      HOLD  = 2'b11
   } fetch_state_t;

   // Instructions are word aligned, so the two low address bits are always cleared.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side handshake.
interface fetch_stage_if;
   import olivia_pkg::*;

   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               if_valid;
   logic               if_ready;
   logic [INSTR_W-1:0] if_instr;
   logic [ADDR_W-1:0]  if_pc;

   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
   );

endinterface

// File: rtl/fetch_stage_perf_counters.sv
// Saturating fetched/flushed event counters; only present when FETCH_PERF_EN is defined.
`ifdef FETCH_PERF_EN
module fetch_perf_counters (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetched_inc,
   input  logic        flushed_inc,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
);

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         if (fetched_inc && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
         if (flushed_inc && (perf_flushed != '1)) perf_flushed <= perf_flushed + 32'd1;
      end
   end

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, held instruction to decode, branch redirect.
// Define FETCH_PERF_EN to add the perf_fetched/perf_flushed counter outputs.
module fetch_stage
   import olivia_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   fetch_stage_if.master     bus,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_flushed
`endif
);

   fetch_state_t       state, state_next;
   logic [ADDR_W-1:0]  pc, pc_next;
   logic [ADDR_W-1:0]  pc_q;
   logic [INSTR_W-1:0] instr_q;
   logic               valid_q, valid_next;
   logic               capture;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         pc      <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         state   <= state_next;
         pc      <= pc_next;
         valid_q <= valid_next;
         if (capture) begin
            instr_q <= bus.imem_rsp_data;
            pc_q    <= pc;
         end
      end
   end

   // A redirect wins over every other event; a response still owed to memory sends us to DROP.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      valid_next = valid_q;
      capture    = 1'b0;
      if (redirect) begin
         pc_next = align_pc(redirect_pc);
         case (state)
            WAIT, DROP: state_next = bus.imem_rsp_valid ? FETCH : DROP;
            HOLD: begin
               valid_next = 1'b0;
               state_next = FETCH;
            end
            default: state_next = FETCH;
         endcase
      end else begin
         case (state)
            FETCH: if (bus.imem_req_ready) state_next = WAIT;
            WAIT: if (bus.imem_rsp_valid) begin
               capture    = 1'b1;
               valid_next = 1'b1;
               pc_next    = pc + PC_STEP;
               state_next = HOLD;
            end
            HOLD: if (bus.if_ready) begin
               valid_next = 1'b0;
               state_next = FETCH;
            end
            DROP: if (bus.imem_rsp_valid) state_next = FETCH;
            default: state_next = FETCH;
         endcase
      end
   end

   assign bus.imem_req_valid = (state == FETCH) && !redirect;
   assign bus.imem_req_addr  = pc;
   assign bus.if_valid       = valid_q;
   assign bus.if_instr       = instr_q;
   assign bus.if_pc          = pc_q;

`ifdef FETCH_PERF_EN
   logic fetched_inc;
   logic flushed_inc;

   assign fetched_inc = (state == HOLD) && bus.if_ready && !redirect;
   assign flushed_inc = (redirect && (state == HOLD)) ||
                        (bus.imem_rsp_valid && ((state == DROP) || ((state == WAIT) && redirect)));

   fetch_perf_counters u_perf (
      .clk          (clk),
      .reset        (reset),
      .fetched_inc  (fetched_inc),
      .flushed_inc  (flushed_inc),
      .perf_fetched (perf_fetched),
      .perf_flushed (perf_flushed)
   );
`endif

   // Memory may only answer a request that is actually outstanding.
   rsp_only_when_outstanding: assert property (
      @(posedge clk) disable iff (reset)
      bus.imem_rsp_valid |-> ((state == WAIT) || (state == DROP))
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized memory/decode/redirect traffic
// checked against a program-order reference model.
module tb_fetch_stage;
   import olivia_pkg::*;

   localparam logic [ADDR_W-1:0] RST_PC = 64'h100;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              redirect = 1'b0;
   logic [ADDR_W-1:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
   logic [31:0]       perf_fetched;
   logic [31:0]       perf_flushed;
`endif

   fetch_stage_if bus ();

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_flushed (perf_flushed)
`endif
   );

   always #5 clk = ~clk;

   // Stimulus for the next cycle
   logic              drv_reset, drv_req_ready, drv_if_ready, drv_redirect;
   logic [ADDR_W-1:0] drv_redirect_pc;
   logic              fixed_mode;
   int                delay_lo, delay_hi;

   // Memory model and program-order reference
   logic              pend, stale;
   logic [ADDR_W-1:0] pend_addr;
   int                pend_delay;
   logic [ADDR_W-1:0] exp_pc;
   int unsigned       m_fetched, m_flushed;
   logic              prev_hold;
   logic [ADDR_W-1:0] prev_pc;
   logic [31:0]       prev_instr;
   int                stall, max_stall;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
      if (fixed_mode) return 32'h8B020020;
      return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   // Reference: instructions reach decode in program order from RESET_PC, each at pc+4
   // of the previous one, except that a redirect restarts the sequence at the aligned target.
   task automatic modelCycle();
      logic fire, accept;
      if (reset) begin
         checkOutput("rst_if_valid", bus.if_valid, 0);
         checkOutput("rst_if_pc", bus.if_pc, 0);
         checkOutput("rst_if_instr", bus.if_instr, 0);
         checkOutput("rst_req_addr", bus.imem_req_addr, RST_PC);
         exp_pc = RST_PC; pend = 0; stale = 0; prev_hold = 0; stall = 0;
         m_fetched = 0; m_flushed = 0;
         return;
      end
      fire   = bus.imem_req_valid && bus.imem_req_ready;
      accept = bus.if_valid && bus.if_ready && !redirect;
      if (prev_hold) begin
         checkOutput("hold_valid", bus.if_valid, 1);
         checkOutput("hold_pc", bus.if_pc, prev_pc);
         checkOutput("hold_instr", bus.if_instr, prev_instr);
      end
      if (bus.if_valid) checkOutput("hold_no_req", bus.imem_req_valid, 0);
      if (redirect) begin
         checkOutput("redirect_blocks_req", bus.imem_req_valid, 0);
         if (pend) stale = 1;
         if (bus.if_valid) m_flushed++;
         exp_pc = redirect_pc & ~64'd3;
      end
      if (bus.imem_rsp_valid) begin
         if (stale) m_flushed++;
         pend = 0; stale = 0;
      end
      if (accept) begin
         checkOutput("if_pc", bus.if_pc, exp_pc);
         checkOutput("if_instr", bus.if_instr, mem_word(exp_pc));
         exp_pc = exp_pc + 64'd4;
         m_fetched++;
      end
      if (fire) begin
         checkOutput("req_addr", bus.imem_req_addr, exp_pc);
         checkOutput("one_outstanding", pend, 0);
         pend = 1; stale = 0; pend_addr = bus.imem_req_addr;
         pend_delay = $urandom_range(delay_hi, delay_lo);
      end
      prev_hold  = bus.if_valid && !accept && !redirect;
      prev_pc    = bus.if_pc;
      prev_instr = bus.if_instr;
      if (fire || accept || redirect || bus.imem_rsp_valid) stall = 0;
      else stall++;
      if (stall > max_stall) max_stall = stall;
   endtask

   // Drive one cycle just after the rising edge, then sample on the falling edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      reset              = drv_reset;
      bus.imem_req_ready = drv_req_ready;
      bus.if_ready       = drv_if_ready;
      redirect           = drv_redirect;
      redirect_pc        = drv_redirect_pc;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (drv_reset) pend = 0;
      else if (pend) begin
         if (pend_delay == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = (stale || drv_redirect) ? 32'hDEADBEEF : mem_word(pend_addr);
         end else pend_delay--;
      end
      @(negedge clk);
      modelCycle();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.imem_req_ready = 0; bus.if_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
      pend = 0; stale = 0; pend_addr = '0; pend_delay = 0; exp_pc = RST_PC;
      m_fetched = 0; m_flushed = 0; prev_hold = 0; prev_pc = '0; prev_instr = '0;
      stall = 0; max_stall = 0;
      drv_reset = 1; drv_req_ready = 1; drv_if_ready = 1; drv_redirect = 0; drv_redirect_pc = '0;
      fixed_mode = 1; delay_lo = 0; delay_hi = 0;
      repeat (3) applyStimulus();

      $display("[TB] zero-wait fetch after reset");
      drv_reset = 0;
      applyStimulus();
      checkOutput("c1_req_valid", bus.imem_req_valid, 1);
      checkOutput("c1_req_addr", bus.imem_req_addr, 64'h100);
      applyStimulus();
      checkOutput("c2_if_valid", bus.if_valid, 0);
      applyStimulus();
      checkOutput("c3_if_valid", bus.if_valid, 1);
      checkOutput("c3_if_pc", bus.if_pc, 64'h100);
      checkOutput("c3_if_instr", bus.if_instr, 32'h8B020020);
      applyStimulus();
      checkOutput("c4_req_valid", bus.imem_req_valid, 1);
      checkOutput("c4_req_addr", bus.imem_req_addr, 64'h104);

      $display("[TB] decode back-pressure");
      drv_if_ready = 0;
      for (int i = 0; i < 10 && !bus.if_valid; i++) applyStimulus();
      checkOutput("bp_if_valid", bus.if_valid, 1);
      repeat (5) begin
         applyStimulus();
         checkOutput("bp_if_pc", bus.if_pc, 64'h104);
         checkOutput("bp_no_req", bus.imem_req_valid, 0);
      end
      drv_if_ready = 1;
      applyStimulus();
      checkOutput("bp_accept_valid", bus.if_valid, 1);
      delay_lo = 3; delay_hi = 3;
      applyStimulus();
      checkOutput("bp_after_valid", bus.if_valid, 0);
      checkOutput("bp_after_addr", bus.imem_req_addr, 64'h108);

      $display("[TB] redirect while waiting");
      drv_redirect = 1; drv_redirect_pc = 64'h200;
      applyStimulus();
      checkOutput("rw_no_req", bus.imem_req_valid, 0);
      drv_redirect = 0; delay_lo = 0; delay_hi = 0; drv_if_ready = 0;
      applyStimulus();
      checkOutput("rw_drop_no_req", bus.imem_req_valid, 0);
      for (int i = 0; i < 10 && !bus.imem_req_valid; i++) applyStimulus();
      checkOutput("rw_req_valid", bus.imem_req_valid, 1);
      checkOutput("rw_req_addr", bus.imem_req_addr, 64'h200);
      for (int i = 0; i < 10 && !bus.if_valid; i++) applyStimulus();
      checkOutput("rw_if_pc", bus.if_pc, 64'h200);
      checkOutput("rw_not_stale", bus.if_instr == 32'hDEADBEEF, 0);

      $display("[TB] redirect while holding");
      drv_if_ready = 1; drv_redirect = 1; drv_redirect_pc = 64'h303;
      applyStimulus();
      checkOutput("rh_if_valid_during", bus.if_valid, 1);
      drv_redirect = 0; drv_req_ready = 0;
      applyStimulus();
      checkOutput("rh_if_valid", bus.if_valid, 0);
      checkOutput("rh_req_valid", bus.imem_req_valid, 1);
      checkOutput("rh_req_addr", bus.imem_req_addr, 64'h300);

      $display("[TB] memory back-pressure");
      repeat (3) begin
         applyStimulus();
         checkOutput("mb_req_valid", bus.imem_req_valid, 1);
         checkOutput("mb_req_addr", bus.imem_req_addr, 64'h300);
      end
      drv_req_ready = 1; delay_lo = 2; delay_hi = 2;
      applyStimulus();
      checkOutput("mb_fire_addr", bus.imem_req_addr, 64'h300);
      applyStimulus();
      checkOutput("mb_wait_no_req", bus.imem_req_valid, 0);
`ifdef FETCH_PERF_EN
      checkOutput("perf_fetched_dir", perf_fetched, m_fetched);
      checkOutput("perf_flushed_dir", perf_flushed, m_flushed);
`endif

      $display("[TB] asynchronous reset while waiting");
      drv_reset = 1;
      #2 reset = 1'b1;
      #1;
      checkOutput("ar_if_valid", bus.if_valid, 0);
      checkOutput("ar_if_pc", bus.if_pc, 0);
      checkOutput("ar_if_instr", bus.if_instr, 0);
      checkOutput("ar_req_valid", bus.imem_req_valid, 1);
      checkOutput("ar_req_addr", bus.imem_req_addr, 64'h100);
`ifdef FETCH_PERF_EN
      checkOutput("ar_perf_fetched", perf_fetched, 0);
      checkOutput("ar_perf_flushed", perf_flushed, 0);
`endif
      repeat (2) applyStimulus();

      $display("[TB] randomized traffic");
      fixed_mode = 0; delay_lo = 0; delay_hi = 2; drv_reset = 0; max_stall = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         drv_req_ready   = ($urandom_range(3, 0) != 0);
         drv_if_ready    = ($urandom_range(2, 0) != 0);
         drv_redirect    = ($urandom_range(15, 0) == 0);
         drv_redirect_pc = ($urandom_range(3, 0) == 0) ?
                           (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0))) :
                           {$urandom, $urandom};
         applyStimulus();
      end
      checkOutput("rnd_liveness", max_stall <= 30, 1);
      checkOutput("rnd_progress", m_fetched > 200, 1);
`ifdef FETCH_PERF_EN
      checkOutput("perf_fetched_rnd", perf_fetched, m_fetched);
      checkOutput("perf_flushed_rnd", perf_flushed, m_flushed);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
